// File: rtl/alu_mul_sequencer_if.sv
// ALU bus shared between the main datapath and the multiply sequencer.
// Signals:
//   alu_req   - sequencer wants the ALU this cycle
//   alu_gnt   - ALU granted; a micro-op retires when req and gnt are both high
//   alu_a/b   - 32-bit operands
//   alu_gin   - control line (3'b010 ADD, 3'b011 SRL of operand b)
//   alu_shamt - shift amount
//   alu_sum   - combinational result, same cycle
//   alu_zout  - result-is-zero flag, same cycle
// The master modport is the sequencer; the slave modport is the ALU/arbiter side.
interface alu_mul_sequencer_if;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_gin;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_sum;
    logic        alu_zout;

    modport master (
        output alu_req, alu_a, alu_b, alu_gin, alu_shamt,
        input  alu_gnt, alu_sum, alu_zout
    );

    modport slave (
        input  alu_req, alu_a, alu_b, alu_gin, alu_shamt,
        output alu_gnt, alu_sum, alu_zout
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle 32x32 unsigned multiplier (low 32 bits of the product) that owns
// no arithmetic of its own: every add and shift is a micro-op issued to the
// shared ALU, and the ALU result is latched back into acc/mcand/mplier.
// Ports:
//   clk, rst_n      - clock (rising edge) and asynchronous active-low reset
//   start           - accepted only while idle; samples op_a/op_b
//   op_a, op_b      - multiplicand, multiplier
//   busy            - high while micro-ops are being sequenced
//   done            - one-cycle pulse; product valid from this cycle
//   product         - registered result, held until the next completion
//   alu             - ALU bus (master side)
// Parameters:
//   EARLY_EXIT      - 1: stop once the remaining multiplier is zero
//   SKIP_ZERO_ACC   - 1: skip ACC when multiplier bit 0 is 0; 0: issue ACC with b=0
module alu_mul_sequencer #(
    parameter int EARLY_EXIT    = 1,
    parameter int SKIP_ZERO_ACC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          op_a,
    input  logic [31:0]          op_b,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          product,
    alu_mul_sequencer_if.master  alu
);

    typedef enum logic [2:0] {IDLE, ACC, DBL, SHR, DONE} state_t;

    localparam logic [2:0] GIN_ADD = 3'b010;
    localparam logic [2:0] GIN_SRL = 3'b011;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] product_q, product_d;
    // Six bits so the 32nd iteration (cnt_q == 31) never aliases back to 0.
    logic [5:0]  cnt_q, cnt_d;

    // Entry point of each iteration: ACC is skipped only when the current
    // multiplier bit is 0 and skipping is enabled.
    function automatic state_t first_op(input logic bit0);
        if (bit0 || (SKIP_ZERO_ACC == 0)) return ACC;
        else                              return DBL;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    // Without a grant every register holds, so a stalled micro-op simply
    // replays the same ALU request next cycle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    if ((op_b == 32'd0) && (EARLY_EXIT != 0)) begin
                        // acc is being cleared this same edge, so the result is 0.
                        state_d   = DONE;
                        product_d = '0;
                    end else begin
                        state_d = first_op(op_b[0]);
                    end
                end
            end
            ACC: begin
                if (alu.alu_gnt) begin
                    acc_d   = alu.alu_sum;
                    state_d = DBL;
                end
            end
            DBL: begin
                if (alu.alu_gnt) begin
                    mcand_d = alu.alu_sum;
                    state_d = SHR;
                end
            end
            SHR: begin
                if (alu.alu_gnt) begin
                    mplier_d = alu.alu_sum;
                    cnt_d    = 6'(cnt_q + 6'd1);
                    if (((EARLY_EXIT != 0) && alu.alu_zout) || (cnt_q == 6'd31)) begin
                        state_d   = DONE;
                        product_d = acc_q;
                    end else begin
                        state_d = first_op(alu.alu_sum[0]);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        alu.alu_req   = 1'b0;
        alu.alu_a     = '0;
        alu.alu_b     = '0;
        alu.alu_gin   = GIN_ADD;
        alu.alu_shamt = '0;
        case (state_q)
            ACC: begin
                busy        = 1'b1;
                alu.alu_req = 1'b1;
                alu.alu_a   = acc_q;
                alu.alu_b   = mplier_q[0] ? mcand_q : 32'd0;
            end
            DBL: begin
                busy        = 1'b1;
                alu.alu_req = 1'b1;
                alu.alu_a   = mcand_q;
                alu.alu_b   = mcand_q;
            end
            SHR: begin
                busy          = 1'b1;
                alu.alu_req   = 1'b1;
                alu.alu_b     = mplier_q;
                alu.alu_gin   = GIN_SRL;
                alu.alu_shamt = 5'd1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign product = product_q;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle controller that computes a 32x32 unsigned multiply (low 32 bits) by sequencing the shared 32-bit combinational ALU through shift-add micro-operations. It never computes internally: it only drives the ALU operand, control-line and shamt inputs, and latches the ALU sum back. It requests the ALU through a req/gnt pair because the main datapath also uses it, and it stalls without losing state when not granted.

Parameters:
EARLY_EXIT, 1, 1 = finish as soon as the remaining multiplier is zero; 0 = always run 32 iterations.
SKIP_ZERO_ACC, 1, 1 = skip the ACC micro-op when multiplier bit 0 is 0; 0 = issue ACC with operand b forced to 0.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request to multiply; accepted only while busy=0
op_a  in  32  multiplicand, sampled on accept
op_b  in  32  multiplier, sampled on accept
busy  out  1  high from the cycle after accept until done is high
done  out  1  one-cycle pulse; product is valid from this cycle on
product  out  32  registered result (op_a*op_b) mod 2^32, held until the next accept
alu_req  out  1  high in micro-op states ACC/DBL/SHR
alu_gnt  in  1  ALU granted this cycle; a micro-op retires only when req and gnt are both high
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_gin  out  3  ALU control line (010 ADD, 011 SRL)
alu_shamt  out  5  ALU shift amount
alu_sum  in  32  ALU result (combinational, same cycle)
alu_zout  in  1  ALU zero flag, same cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, product=0, alu_req=0; internal acc/mcand/mplier=0; iteration count=0. Reset mid-operation abandons the operation; no done pulse.
- ALU outputs are decoded combinationally from the state and registers. IDLE/DONE: alu_a=0, alu_b=0, alu_gin=010, alu_shamt=0.
- States: IDLE, ACC, DBL, SHR, DONE.
- IDLE: on start, latch mcand=op_a, mplier=op_b, acc=0, cnt=0.
  - If op_b==0 and EARLY_EXIT=1, go to DONE.
  - Otherwise, if mplier[0]=1 or SKIP_ZERO_ACC=0, go to ACC; else go to DBL.
  - start while busy=1 is ignored (not queued).
- ACC: drive a=acc, b=mcand (or 0 if mplier[0]=0), gin=010. On gnt: acc<=alu_sum, then go to DBL.
- DBL: drive a=mcand, b=mcand, gin=010. On gnt: mcand<=alu_sum, then go to SHR.
- SHR: drive a=0, b=mplier, gin=011, shamt=1. On gnt: mplier<=alu_sum and cnt<=cnt+1, then choose the next state:
  - DONE if (EARLY_EXIT=1 and alu_zout=1) or cnt==31.
  - Otherwise ACC/DBL, chosen by alu_sum[0] using the IDLE rule.
- Any micro-op state with gnt=0: hold the state and all registers, keep ALU outputs stable, keep alu_req=1.
- DONE: on entry product<=acc. In DONE, done=1 and busy=0 for exactly one cycle, then go to IDLE. start in the DONE cycle is ignored.
- Arithmetic: all adds wrap mod 2^32, and carry-out is discarded. The final DBL may overflow mcand; this is harmless.
- Latency with gnt held at 1: 1 + sum over iterations of (2 or 3) cycles from the accept edge to done. The worst case is 96 micro-op cycles + DONE.

Test Plan:
- a=3, b=5, gnt=1, defaults -> micro-op sequence ACC,DBL,SHR,DBL,SHR,ACC,DBL,SHR (8 cycles); done 9 cycles after accept; product=15.
- a=0x12345678, b=0 -> DONE the cycle after accept, no alu_req; product=0. With EARLY_EXIT=0 -> 32 iterations, product=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0x00000001 (wrap); 32 iterations of 3 micro-ops, done after 97 cycles.
- a=7, b=6 with gnt toggling 1,0,0,1,... -> state and ALU outputs frozen while gnt=0; product=42; done delayed by exactly the number of gnt=0 cycles.
- start pulsed while busy, and again on the done cycle -> both ignored, product unchanged; the next start in IDLE is accepted.
- rst_n=0 asserted during DBL of a=9, b=9 -> busy, done, alu_req and product immediately 0; after release, state is IDLE and a fresh 9*9 gives 81.
